alu_pipe: RTL and testbench

Parametrised, pipelined ALU with registered outputs, a valid/ready handshake on both sides, and an internal accumulator so that chained operations can reuse the previous result. It generalises the fixed 4-bit combinational ALU to WIDTH-bit operands and a 2*WIDTH-bit result. It adds status flags and back-pressure, and sits between an operand/command source and any result consumer in the datapath.

---
 rtl/alu_pipe_pkg.sv | 40 ++++
 rtl/alu_pipe_core.sv | 72 +++++++
 rtl/alu_pipe.sv | 139 +++++++++++++
 tb/tb_alu_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_pipe_pkg
// Brief    : Shared types and operation encodings for the pipelined ALU.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_pipe_pkg;

   // Operation select within a group
   typedef logic [2:0] sel_t;

   // Status flags produced alongside every result
   typedef struct packed {
      logic equal;
      logic carry;
      logic zero;
   } alu_flags_t;

   // {mode, sel} encodings: mode=1 arithmetic group, mode=0 logic group
   localparam logic [3:0] OP_ADD   = 4'b1_000;
   localparam logic [3:0] OP_SUB   = 4'b1_001;
   localparam logic [3:0] OP_INC   = 4'b1_010;
   localparam logic [3:0] OP_DEC   = 4'b1_011;
   localparam logic [3:0] OP_MUL   = 4'b1_100;
   localparam logic [3:0] OP_CMP   = 4'b1_101;
   localparam logic [3:0] OP_PASSA = 4'b1_110;
   localparam logic [3:0] OP_NEG   = 4'b1_111;
   localparam logic [3:0] OP_AND   = 4'b0_000;
   localparam logic [3:0] OP_OR    = 4'b0_001;
   localparam logic [3:0] OP_XOR   = 4'b0_010;
   localparam logic [3:0] OP_NOT   = 4'b0_011;
   localparam logic [3:0] OP_NAND  = 4'b0_100;
   localparam logic [3:0] OP_NOR   = 4'b0_101;
   localparam logic [3:0] OP_XNOR  = 4'b0_110;
   localparam logic [3:0] OP_SHL   = 4'b0_111;

endpackage

`default_nettype wire

// File: rtl/alu_pipe_core.sv
//------------------------------------------------------------------------------
// Module   : alu_core
// Brief    : Combinational WIDTH-bit ALU with 2*WIDTH-bit result and flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_core
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  sel_t               sel,
   input  logic               mode,
   input  logic               c_in,
   output logic [2*WIDTH-1:0] result,
   output alu_flags_t         flags
);

   // One extra bit on every narrow sum so bit WIDTH is the carry/borrow out
   logic [WIDTH:0]     add_s, sub_s, inc_s, dec_s, neg_s;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   narrow;
   logic               cy;
   logic               use_wide;

   assign add_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
   assign sub_s = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, c_in};
   assign inc_s = {1'b0, a} + (WIDTH+1)'(1);
   assign dec_s = {1'b0, a} - (WIDTH+1)'(1);
   assign neg_s = (WIDTH+1)'(0) - {1'b0, a};
   assign prod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   // Select the operation; only MUL uses the full-width product
   always_comb begin
      narrow   = '0;
      cy       = 1'b0;
      use_wide = 1'b0;
      case ({mode, sel})
         OP_ADD:   begin narrow = add_s[WIDTH-1:0]; cy = add_s[WIDTH]; end
         OP_SUB:   begin narrow = sub_s[WIDTH-1:0]; cy = sub_s[WIDTH]; end
         OP_INC:   begin narrow = inc_s[WIDTH-1:0]; cy = inc_s[WIDTH]; end
         OP_DEC:   begin narrow = dec_s[WIDTH-1:0]; cy = dec_s[WIDTH]; end
         OP_MUL:   use_wide = 1'b1;
         OP_CMP:   narrow = '0;
         OP_PASSA: narrow = a;
         OP_NEG:   begin narrow = neg_s[WIDTH-1:0]; cy = neg_s[WIDTH]; end
         OP_AND:   narrow = a & b;
         OP_OR:    narrow = a | b;
         OP_XOR:   narrow = a ^ b;
         OP_NOT:   narrow = ~a;
         OP_NAND:  narrow = ~(a & b);
         OP_NOR:   narrow = ~(a | b);
         OP_XNOR:  narrow = ~(a ^ b);
         OP_SHL:   begin narrow = {a[WIDTH-2:0], c_in}; cy = a[WIDTH-1]; end
         default:  narrow = '0;
      endcase
   end

   // Widen the result and derive flags over the full result width
   always_comb begin
      result      = use_wide ? prod : {{WIDTH{1'b0}}, narrow};
      flags.equal = (a == b);
      flags.carry = cy;
      flags.zero  = (result == '0);
   end

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
//------------------------------------------------------------------------------
// Module   : alu_pipe
// Brief    : Two-stage pipelined ALU with valid/ready handshake and a chaining
//            accumulator holding the low half of the latest S2 result.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   op1,
   input  logic [WIDTH-1:0]   op2,
   input  sel_t               sel,
   input  logic               c_in,
   input  logic               mode,
   input  logic               acc_en,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               equal,
   output logic               carry,
   output logic               zero
);

   // Stage S1: captured command
   logic               s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0]   s1_op1_q, s1_op1_d;
   logic [WIDTH-1:0]   s1_op2_q, s1_op2_d;
   sel_t               s1_sel_q, s1_sel_d;
   logic               s1_mode_q, s1_mode_d;
   logic               s1_cin_q, s1_cin_d;
   logic               s1_acc_en_q, s1_acc_en_d;
   // Stage S2: registered result, flags and accumulator
   logic               out_valid_q, out_valid_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   alu_flags_t         flags_q, flags_d;
   logic [WIDTH-1:0]   acc_q, acc_d;

   logic               s2_adv, s1_adv, accept;
   logic [WIDTH-1:0]   core_a;
   logic [2*WIDTH-1:0] core_res;
   alu_flags_t         core_flags;

   assign s2_adv   = !out_valid_q || out_ready;
   assign s1_adv   = s1_valid_q && s2_adv;
   assign in_ready = !s1_valid_q || s2_adv;
   assign accept   = in_valid && in_ready;
   assign core_a   = s1_acc_en_q ? acc_q : s1_op1_q;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .a      (core_a),
      .b      (s1_op2_q),
      .sel    (s1_sel_q),
      .mode   (s1_mode_q),
      .c_in   (s1_cin_q),
      .result (core_res),
      .flags  (core_flags)
   );

   // S1 empties when it advances and refills on an accepted command
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_op1_d    = s1_op1_q;
      s1_op2_d    = s1_op2_q;
      s1_sel_d    = s1_sel_q;
      s1_mode_d   = s1_mode_q;
      s1_cin_d    = s1_cin_q;
      s1_acc_en_d = s1_acc_en_q;
      if (s1_adv) s1_valid_d = 1'b0;
      if (accept) begin
         s1_valid_d  = 1'b1;
         s1_op1_d    = op1;
         s1_op2_d    = op2;
         s1_sel_d    = sel;
         s1_mode_d   = mode;
         s1_cin_d    = c_in;
         s1_acc_en_d = acc_en;
      end
   end

   // S2 and the accumulator only change when S2 is free to advance
   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      flags_d     = flags_q;
      acc_d       = acc_q;
      if (s2_adv) out_valid_d = s1_valid_q;
      if (s1_adv) begin
         result_d = core_res;
         flags_d  = core_flags;
         acc_d    = core_res[WIDTH-1:0];
      end
   end

   // Pipeline registers with asynchronous clear
   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         s1_valid_q  <= 1'b0;
         s1_op1_q    <= '0;
         s1_op2_q    <= '0;
         s1_sel_q    <= '0;
         s1_mode_q   <= 1'b0;
         s1_cin_q    <= 1'b0;
         s1_acc_en_q <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
         acc_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op1_q    <= s1_op1_d;
         s1_op2_q    <= s1_op2_d;
         s1_sel_q    <= s1_sel_d;
         s1_mode_q   <= s1_mode_d;
         s1_cin_q    <= s1_cin_d;
         s1_acc_en_q <= s1_acc_en_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         acc_q       <= acc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign equal     = flags_q.equal;
   assign carry     = flags_q.carry;
   assign zero      = flags_q.zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_pipe
// Brief    : Self-checking bench for alu_pipe (vector table, directed
//            handshake sequences, randomized traffic against a model).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_pipe;
   import alu_pipe_pkg::*;

   localparam int W = 4;
   localparam int M = 1 << W;

   logic           clk = 1'b0;
   logic           rstb = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   op1 = '0, op2 = '0;
   sel_t           sel = '0;
   logic           c_in = 1'b0, mode = 1'b0, acc_en = 1'b0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [2*W-1:0] result;
   logic           equal, carry, zero;

   alu_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready),
      .op1(op1), .op2(op2), .sel(sel), .c_in(c_in), .mode(mode),
      .acc_en(acc_en), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .equal(equal), .carry(carry), .zero(zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*W-1:0] res;
      logic           eq;
      logic           cy;
      logic           z;
   } exp_t;

   typedef struct {
      logic     m;
      sel_t     s;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic     ci;
      exp_t     e;
   } vec_t;

   int     checks = 0;
   int     failures = 0;
   int     cyc = 0;
   exp_t   exp_q[$];
   int     out_cyc[$];
   logic [W-1:0] m_acc = '0;
   bit     rnd_on = 1'b0;

   // Reference: operation semantics in plain integer arithmetic
   function automatic exp_t model(input logic m, input int s, input int a, input int b, input int ci);
      exp_t e;
      int r = 0;
      int cy = 0;
      if (m) begin
         case (s)
            0: begin r = a + b + ci; cy = (r >= M) ? 1 : 0; r = r % M; end
            1: begin r = a - b - ci; cy = (r < 0) ? 1 : 0; r = (r + M) % M; end
            2: begin r = a + 1; cy = (r >= M) ? 1 : 0; r = r % M; end
            3: begin r = a - 1; cy = (r < 0) ? 1 : 0; r = (r + M) % M; end
            4: r = a * b;
            5: r = 0;
            6: r = a;
            default: begin r = -a; cy = (r < 0) ? 1 : 0; r = (r + M) % M; end
         endcase
      end else begin
         case (s)
            0: r = a & b;
            1: r = a | b;
            2: r = a ^ b;
            3: r = (M - 1) - a;
            4: r = (M - 1) - (a & b);
            5: r = (M - 1) - (a | b);
            6: r = (M - 1) - (a ^ b);
            default: begin r = (a * 2 + ci) % M; cy = (a >= M / 2) ? 1 : 0; end
         endcase
      end
      e.res = (2*W)'(r);
      e.eq  = (a == b);
      e.cy  = cy[0];
      e.z   = (r == 0);
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: compare every output transfer against the expected queue
   always @(negedge clk) begin
      if (!rstb && out_valid && out_ready) begin
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL unexpected_out: got result=%h with no result pending", result);
         end else begin
            if (result !== exp_q[0].res || equal !== exp_q[0].eq ||
                carry !== exp_q[0].cy || zero !== exp_q[0].z) begin
               failures = failures + 1;
               $display("FAIL out_data: got res=%h eq=%b cy=%b z=%b, want res=%h eq=%b cy=%b z=%b",
                        result, equal, carry, zero, exp_q[0].res, exp_q[0].eq, exp_q[0].cy, exp_q[0].z);
            end
            void'(exp_q.pop_front());
         end
         out_cyc.push_back(cyc);
      end
   end

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
      checks = checks + 1;
      if (got !== want) begin
         failures = failures + 1;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Issue one command (called just after a rising edge); waits for acceptance
   task automatic send(input logic m, input sel_t s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic ae, input bit use_e, input exp_t e);
      bit   got = 1'b0;
      bit   rdy;
      exp_t x;
      in_valid = 1'b1; mode = m; sel = s; op1 = a; op2 = b; c_in = ci; acc_en = ae;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); rdy = in_ready;
         @(posedge clk);
         if (rdy) begin got = 1'b1; break; end
      end
      if (got) begin
         x = use_e ? e : model(m, int'(s), ae ? int'(m_acc) : int'(a), int'(b), int'(ci));
         exp_q.push_back(x);
         m_acc = x.res[W-1:0];
      end else begin
         checks = checks + 1;
         failures = failures + 1;
         $display("FAIL accept_timeout: got no acceptance want in_ready");
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
      #1;
      checks = checks + 1;
      if (exp_q.size() != 0) begin
         failures = failures + 1;
         $display("FAIL drain: got %0d results outstanding want 0", exp_q.size());
      end
   endtask

   vec_t vecs[18];
   exp_t none;

   initial begin
      none = '{res: '0, eq: 1'b0, cy: 1'b0, z: 1'b0};
      vecs[0]  = '{1'b1, 3'd0, 4'h1, 4'h1, 1'b0, '{8'h02, 1'b1, 1'b0, 1'b0}};
      vecs[1]  = '{1'b1, 3'd0, 4'hF, 4'h1, 1'b0, '{8'h00, 1'b0, 1'b1, 1'b1}};
      vecs[2]  = '{1'b1, 3'd1, 4'h3, 4'h5, 1'b0, '{8'h0E, 1'b0, 1'b1, 1'b0}};
      vecs[3]  = '{1'b1, 3'd4, 4'hF, 4'hF, 1'b0, '{8'hE1, 1'b1, 1'b0, 1'b0}};
      vecs[4]  = '{1'b1, 3'd2, 4'hF, 4'h0, 1'b0, '{8'h00, 1'b0, 1'b1, 1'b1}};
      vecs[5]  = '{1'b1, 3'd3, 4'h0, 4'h0, 1'b0, '{8'h0F, 1'b1, 1'b1, 1'b0}};
      vecs[6]  = '{1'b1, 3'd7, 4'h1, 4'h1, 1'b0, '{8'h0F, 1'b1, 1'b1, 1'b0}};
      vecs[7]  = '{1'b1, 3'd5, 4'h5, 4'h5, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1}};
      vecs[8]  = '{1'b1, 3'd6, 4'h7, 4'h3, 1'b0, '{8'h07, 1'b0, 1'b0, 1'b0}};
      vecs[9]  = '{1'b1, 3'd1, 4'h5, 4'h2, 1'b1, '{8'h02, 1'b0, 1'b0, 1'b0}};
      vecs[10] = '{1'b0, 3'd0, 4'hA, 4'h6, 1'b1, '{8'h02, 1'b0, 1'b0, 1'b0}};
      vecs[11] = '{1'b0, 3'd1, 4'hA, 4'h6, 1'b1, '{8'h0E, 1'b0, 1'b0, 1'b0}};
      vecs[12] = '{1'b0, 3'd2, 4'hA, 4'h6, 1'b1, '{8'h0C, 1'b0, 1'b0, 1'b0}};
      vecs[13] = '{1'b0, 3'd3, 4'hA, 4'h6, 1'b1, '{8'h05, 1'b0, 1'b0, 1'b0}};
      vecs[14] = '{1'b0, 3'd4, 4'hA, 4'h6, 1'b1, '{8'h0D, 1'b0, 1'b0, 1'b0}};
      vecs[15] = '{1'b0, 3'd5, 4'hA, 4'h6, 1'b1, '{8'h01, 1'b0, 1'b0, 1'b0}};
      vecs[16] = '{1'b0, 3'd6, 4'hA, 4'h6, 1'b1, '{8'h03, 1'b0, 1'b0, 1'b0}};
      vecs[17] = '{1'b0, 3'd7, 4'hA, 4'h6, 1'b1, '{8'h05, 1'b0, 1'b1, 1'b0}};

      // Reset state
      repeat (3) @(posedge clk);
      #1 rstb = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 16'(out_valid), 16'h0);
      check("rst_result", 16'(result), 16'h0);
      check("rst_flags", 16'({equal, carry, zero}), 16'h0);
      check("rst_in_ready", 16'(in_ready), 16'h1);
      @(posedge clk); #1;

      // Vector table, streamed back to back
      foreach (vecs[i]) send(vecs[i].m, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, 1'b1, vecs[i].e);
      drain();

      // Accumulator chain: 3, 5, 7, 9 with no bubbles
      out_cyc.delete();
      send(1'b1, 3'd6, 4'h3, 4'h0, 1'b0, 1'b0, 1'b1, '{8'h03, 1'b0, 1'b0, 1'b0});
      send(1'b1, 3'd0, 4'hC, 4'h2, 1'b0, 1'b1, 1'b1, '{8'h05, 1'b0, 1'b0, 1'b0});
      send(1'b1, 3'd0, 4'hC, 4'h2, 1'b0, 1'b1, 1'b1, '{8'h07, 1'b0, 1'b0, 1'b0});
      send(1'b1, 3'd0, 4'hC, 4'h2, 1'b0, 1'b1, 1'b1, '{8'h09, 1'b0, 1'b0, 1'b0});
      drain();
      check("chain_count", 16'(out_cyc.size()), 16'd4);
      if (out_cyc.size() == 4) check("chain_bubbles", 16'(out_cyc[3] - out_cyc[0]), 16'd3);

      // Back-pressure: two accepted, then in_ready low and result held
      out_ready = 1'b0;
      send(1'b1, 3'd6, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, none);
      send(1'b1, 3'd6, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, none);
      in_valid = 1'b1; mode = 1'b1; sel = 3'd6; op1 = 4'h3; op2 = 4'h0; acc_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready", 16'(in_ready), 16'h0);
         check("bp_out_valid", 16'(out_valid), 16'h1);
         check("bp_result_hold", 16'(result), 16'h01);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      send(1'b1, 3'd6, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0, none);
      send(1'b1, 3'd6, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0, none);
      drain();

      // Reset with both stages full
      out_ready = 1'b0;
      send(1'b1, 3'd6, 4'h6, 4'h0, 1'b0, 1'b0, 1'b0, none);
      send(1'b1, 3'd6, 4'h7, 4'h0, 1'b0, 1'b0, 1'b0, none);
      #2 check("full_in_ready", 16'(in_ready), 16'h0);
      rstb = 1'b1;
      #1;
      check("arst_out_valid", 16'(out_valid), 16'h0);
      check("arst_result", 16'(result), 16'h0);
      exp_q.delete();
      m_acc = '0;
      @(posedge clk); #1 rstb = 1'b0;
      #1 check("arst_in_ready", 16'(in_ready), 16'h1);
      out_ready = 1'b1;
      send(1'b1, 3'd0, 4'h9, 4'h5, 1'b0, 1'b1, 1'b1, '{8'h05, 1'b0, 1'b0, 1'b0});
      drain();

      // Randomized traffic with random back-pressure
      rnd_on = 1'b1;
      fork
         begin
            while (rnd_on) begin
               @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join_none
      for (int i = 0; i < 300; i++) begin
         send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), W'($urandom_range(0, M - 1)),
              W'($urandom_range(0, M - 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
              1'b0, none);
      end
      rnd_on = 1'b0;
      repeat (2) @(posedge clk);
      #1 out_ready = 1'b1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
